// File: rtl/izh_pkg.sv
// Shared Q16.16 sign-magnitude types, constants and helpers for the Izhikevich
// state-update stage.
package izh_pkg;

  localparam int N = 32;
  localparam int Q = 16;

  typedef logic [N-1:0] fx_t;

  typedef enum logic [2:0] {IDLE, MULT, ADD, CHECK, DONE} state_e;

  localparam fx_t DT     = 32'h0000199A;  // 0.1
  localparam fx_t V_PEAK = 32'h001E0000;  // +30.0
  localparam fx_t C      = 32'h80410000;  // -65.0
  localparam fx_t D      = 32'h00080000;  // +8.0
  localparam fx_t V_INIT = 32'h80410000;  // -65.0
  localparam fx_t W_INIT = 32'h800D0000;  // -13.0

  function automatic fx_t fx_neg_zero_fix(input fx_t x);
    return (x == {1'b1, {(N-1){1'b0}}}) ? '0 : x;
  endfunction

  // Sign-magnitude a >= b; both zeros compare as the same positive zero.
  function automatic logic fx_ge(input fx_t a, input fx_t b);
    fx_t an;
    fx_t bn;
    an = fx_neg_zero_fix(a);
    bn = fx_neg_zero_fix(b);
    if (an[N-1] != bn[N-1]) return bn[N-1];
    else if (!an[N-1])      return an[N-2:0] >= bn[N-2:0];
    else                    return an[N-2:0] <= bn[N-2:0];
  endfunction

endpackage

// File: rtl/izh_fx_sat_addmul.sv
// Saturating sign-magnitude Q16.16 multiplier and adder pair, purely
// combinational, each with its own overflow flag.
module izh_fx_sat_addmul
  import izh_pkg::*;
(
  input  fx_t  mul_a_i,
  input  fx_t  mul_b_i,
  input  fx_t  add_a_i,
  input  fx_t  add_b_i,
  output fx_t  prod_o,
  output fx_t  sum_o,
  output logic mul_ovf_o,
  output logic add_ovf_o
);

  logic [2*N-3:0] prod_full;
  logic [2*N-3:0] prod_shift;
  logic [N-2:0]   mul_mag;
  logic [N-1:0]   sum_full;
  logic [N-2:0]   add_mag;
  logic           add_sgn;

  // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    prod_full  = {{(N-1){1'b0}}, mul_a_i[N-2:0]} * {{(N-1){1'b0}}, mul_b_i[N-2:0]};
    prod_shift = prod_full >> Q;
    mul_ovf_o  = |prod_shift[2*N-3:N-1];
    mul_mag    = mul_ovf_o ? '1 : prod_shift[N-2:0];
    prod_o     = fx_neg_zero_fix({mul_a_i[N-1] ^ mul_b_i[N-1], mul_mag});

    sum_full  = '0;
    add_ovf_o = 1'b0;
    add_sgn   = add_a_i[N-1];
    if (add_a_i[N-1] == add_b_i[N-1]) begin
      sum_full  = {1'b0, add_a_i[N-2:0]} + {1'b0, add_b_i[N-2:0]};
      add_ovf_o = sum_full[N-1];
      add_mag   = add_ovf_o ? '1 : sum_full[N-2:0];
    end else if (add_a_i[N-2:0] >= add_b_i[N-2:0]) begin
      add_mag = add_a_i[N-2:0] - add_b_i[N-2:0];
    end else begin
      add_mag = add_b_i[N-2:0] - add_a_i[N-2:0];
      add_sgn = add_b_i[N-1];
    end
    sum_o = fx_neg_zero_fix({add_sgn, add_mag});
  end

endmodule

// File: rtl/izhikevich_state_update.sv
// Euler integration, spike detection and reset of the Izhikevich v/w state.
// Optional refractory counter enabled by macro IZH_REFRACTORY_EN.
module izhikevich_state_update
  import izh_pkg::*;
`ifdef IZH_REFRACTORY_EN
#(
  parameter int unsigned REFRAC_STEPS = 2
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  fx_t  dv_in,
  input  fx_t  dw_in,
  output logic out_valid,
  input  logic out_ready,
  output fx_t  v_out,
  output fx_t  w_out,
  output logic spike,
  output logic sat
);

  state_e state_q;
  fx_t    dv_q, dw_q, pv_q, pw_q, vn_q, wn_q, v_q, w_q;
  logic   in_ready_q, out_valid_q, spike_q, sat_q;

`ifdef IZH_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_STEPS + 2);
  logic [RW-1:0] refrac_q;
`endif

  fx_t  v_prod, v_sum, w_prod, w_sum, w_add_b, w_add_a;
  logic v_mul_ovf, v_add_ovf, w_mul_ovf, w_add_ovf;

  // The w adder is reused in CHECK to apply the post-spike increment.
  assign w_add_a = (state_q == CHECK) ? wn_q : w_q;
  assign w_add_b = (state_q == CHECK) ? D    : pw_q;

  izh_fx_sat_addmul u_v_path (
    .mul_a_i(dv_q), .mul_b_i(DT), .add_a_i(v_q), .add_b_i(pv_q),
    .prod_o(v_prod), .sum_o(v_sum), .mul_ovf_o(v_mul_ovf), .add_ovf_o(v_add_ovf)
  );

  izh_fx_sat_addmul u_w_path (
    .mul_a_i(dw_q), .mul_b_i(DT), .add_a_i(w_add_a), .add_b_i(w_add_b),
    .prod_o(w_prod), .sum_o(w_sum), .mul_ovf_o(w_mul_ovf), .add_ovf_o(w_add_ovf)
  );

  // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dv_q        <= '0;
      dw_q        <= '0;
      pv_q        <= '0;
      pw_q        <= '0;
      vn_q        <= '0;
      wn_q        <= '0;
      v_q         <= V_INIT;
      w_q         <= W_INIT;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      spike_q     <= 1'b0;
      sat_q       <= 1'b0;
`ifdef IZH_REFRACTORY_EN
      refrac_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            dv_q       <= fx_neg_zero_fix(dv_in);
            dw_q       <= fx_neg_zero_fix(dw_in);
            in_ready_q <= 1'b0;
            state_q    <= MULT;
          end
        end
        MULT: begin
          pv_q    <= fx_neg_zero_fix(v_prod);
          pw_q    <= fx_neg_zero_fix(w_prod);
          sat_q   <= sat_q | v_mul_ovf | w_mul_ovf;
          state_q <= ADD;
        end
        ADD: begin
          vn_q    <= fx_neg_zero_fix(v_sum);
          wn_q    <= fx_neg_zero_fix(w_sum);
          sat_q   <= sat_q | v_add_ovf | w_add_ovf;
          state_q <= CHECK;
        end
        CHECK: begin
          out_valid_q <= 1'b1;
          state_q     <= DONE;
`ifdef IZH_REFRACTORY_EN
          if (refrac_q != '0) begin
            v_q      <= C;
            w_q      <= wn_q;
            spike_q  <= 1'b0;
            refrac_q <= refrac_q - 1'b1;
          end else
`endif
          if (fx_ge(vn_q, V_PEAK)) begin
            v_q     <= C;
            w_q     <= fx_neg_zero_fix(w_sum);
            spike_q <= 1'b1;
            sat_q   <= sat_q | w_add_ovf;
`ifdef IZH_REFRACTORY_EN
            refrac_q <= REFRAC_STEPS[RW-1:0];
`endif
          end else begin
            v_q     <= vn_q;
            w_q     <= wn_q;
            spike_q <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            spike_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign v_out     = v_q;
  assign w_out     = w_q;
  assign spike     = spike_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_izhikevich_state_update.sv
// Self-checking bench for izhikevich_state_update: directed vector table,
// multi-cycle corner sequences and randomized steps against a signed-integer model.
module tb_izhikevich_state_update;

  localparam logic [31:0] V_INIT_C = 32'h80410000;
  localparam logic [31:0] W_INIT_C = 32'h800D0000;
  localparam logic [31:0] C_C      = 32'h80410000;
  localparam longint      DT_I     = 64'd6554;
  localparam longint      PEAK_I   = 64'd30 * 64'd65536;
  localparam longint      D_I      = 64'd8 * 64'd65536;
  localparam longint      LIM      = 64'd2147483647;
  localparam int          REFRAC_N = 2;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, spike, sat;
  logic [31:0] dv_in, dw_in, v_out, w_out;

  int n_checks = 0;
  int n_errors = 0;

  longint m_v, m_w;
  bit     m_sat;
  int     m_ref;

  izhikevich_state_update dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dv_in(dv_in), .dw_in(dw_in), .out_valid(out_valid), .out_ready(out_ready),
    .v_out(v_out), .w_out(w_out), .spike(spike), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model (signed integers in units of 2^-16) -----
  function automatic longint to_int(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] to_fx(input longint x);
    longint m;
    m = (x < 0) ? -x : x;
    return {(x < 0), m[30:0]};
  endfunction

  function automatic longint m_mul(input longint a, input longint b);
    longint mag;
    mag = (((a < 0) ? -a : a) * ((b < 0) ? -b : b)) >> 16;
    if (mag > LIM) begin mag = LIM; m_sat = 1'b1; end
    return ((a < 0) != (b < 0)) ? -mag : mag;
  endfunction

  function automatic longint m_add(input longint a, input longint b);
    longint s;
    s = a + b;
    if (s > LIM)  begin s = LIM;  m_sat = 1'b1; end
    if (s < -LIM) begin s = -LIM; m_sat = 1'b1; end
    return s;
  endfunction

  task automatic model_reset();
    m_v = to_int(V_INIT_C);
    m_w = to_int(W_INIT_C);
    m_sat = 1'b0;
    m_ref = 0;
  endtask

  task automatic model_step(input logic [31:0] dv, input logic [31:0] dw,
                            output logic [31:0] ev, output logic [31:0] ew, output logic es);
    longint vn, wn;
    vn = m_add(m_v, m_mul(to_int(dv), DT_I));
    wn = m_add(m_w, m_mul(to_int(dw), DT_I));
    es = 1'b0;
`ifdef IZH_REFRACTORY_EN
    if (m_ref > 0) begin
      m_v = to_int(C_C);
      m_w = wn;
      m_ref--;
    end else
`endif
    if (vn >= PEAK_I) begin
      m_v = to_int(C_C);
      m_w = m_add(wn, D_I);
      es = 1'b1;
      m_ref = REFRAC_N;
    end else begin
      m_v = vn;
      m_w = wn;
    end
    ev = to_fx(m_v);
    ew = to_fx(m_w);
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #2;
    check("reset v_out", v_out, V_INIT_C);
    check("reset w_out", w_out, W_INIT_C);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset spike", spike, 0);
    check("reset sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, " in_ready"}, in_ready, 1);
  endtask

  task automatic step_and_check(input string tag, input logic [31:0] dv, input logic [31:0] dw,
                                input int hold, output logic [31:0] gv, output logic [31:0] gw,
                                output logic gs);
    logic [31:0] ev, ew;
    logic es;
    int n;
    model_step(dv, dw, ev, ew, es);
    wait_ready(tag);
    dv_in = dv; dw_in = dw; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0; dv_in = $urandom; dw_in = $urandom;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check({tag, " latency"}, n, 3);
    gv = v_out; gw = w_out; gs = spike;
    check({tag, " v_out"}, v_out, ev);
    check({tag, " w_out"}, w_out, ew);
    check({tag, " spike"}, spike, es);
    check({tag, " sat"}, sat, m_sat);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; dv_in = $urandom; dw_in = $urandom;
      @(negedge clk);
      check({tag, " hold out_valid"}, out_valid, 1);
      check({tag, " hold in_ready"}, in_ready, 0);
      check({tag, " hold v_out"}, v_out, ev);
      check({tag, " hold w_out"}, w_out, ew);
      check({tag, " hold spike"}, spike, es);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check({tag, " out_valid cleared"}, out_valid, 0);
    check({tag, " spike cleared"}, spike, 0);
  endtask

  function automatic logic [31:0] rand_fx();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h000FFFFF))};
      1:       r = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h03FFFFFF))};
      2:       r = $urandom;
      default: r = $urandom_range(0, 1) ? 32'h80000000 : 32'h0;
    endcase
    return r;
  endfunction

  typedef struct {
    bit          rst;
    logic [31:0] dv, dw, ev, ew;
    logic        es;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] gv, gw;
    logic gs;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; dv_in = '0; dw_in = '0;
    model_reset();

    vecs[0] = '{1'b1, 32'h00010000, 32'h00000000, 32'h8040E666, 32'h800D0000, 1'b0};
    vecs[1] = '{1'b1, 32'h03E80000, 32'h00000000, 32'h80410000, 32'h80050000, 1'b1};
    vecs[2] = '{1'b1, 32'h80010000, 32'h00010000, 32'h8041199A, 32'h800CE666, 1'b0};
    vecs[3] = '{1'b1, 32'h02EE0000, 32'h00000000, 32'h000A012C, 32'h800D0000, 1'b0};
    vecs[4] = '{1'b1, 32'h03B5F129, 32'h00000000, 32'h80410000, 32'h80050000, 1'b1};
    vecs[5] = '{1'b1, 32'h03B5F128, 32'h00000000, 32'h001DFFFF, 32'h800D0000, 1'b0};

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst) apply_reset();
      step_and_check($sformatf("vec%0d", i), vecs[i].dv, vecs[i].dw, 0, gv, gw, gs);
      check($sformatf("vec%0d table v", i), gv, vecs[i].ev);
      check($sformatf("vec%0d table w", i), gw, vecs[i].ew);
      check($sformatf("vec%0d table spike", i), gs, vecs[i].es);
    end

    // w saturation over eleven large-dw steps
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      step_and_check("satw", 32'h0, 32'h7FFFFFFF, 0, gv, gw, gs);
      if (i == 9) check("satw sat before overflow", sat, 0);
    end
    check("satw w clamped", w_out, 32'h7FFFFFFF);
    check("satw sat set", sat, 1);
    step_and_check("satw after", 32'h0, 32'h0, 0, gv, gw, gs);
    check("satw sat sticky", sat, 1);

    // back-pressure in DONE with ignored in_valid pulses
    apply_reset();
    step_and_check("hold", 32'h00010000, 32'h00010000, 5, gv, gw, gs);
    step_and_check("after hold", 32'h00020000, 32'h0, 0, gv, gw, gs);

    // asynchronous reset while the step sits in ADD
    apply_reset();
    step_and_check("pre abort", 32'h00050000, 32'h00010000, 0, gv, gw, gs);
    wait_ready("abort");
    dv_in = 32'h00100000; dw_in = 32'h00100000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort v_out", v_out, V_INIT_C);
    check("abort w_out", w_out, W_INIT_C);
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 0);
    check("abort spike", spike, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step_and_check("post abort", 32'h00010000, 32'h0, 0, gv, gw, gs);
    check("post abort v", gv, 32'h8040E666);

`ifdef IZH_REFRACTORY_EN
    apply_reset();
    step_and_check("refr fire", 32'h03E80000, 32'h0, 0, gv, gw, gs);
    check("refr fire spike", gs, 1);
    for (int i = 0; i < 2; i++) begin
      step_and_check("refr hold", 32'h03E80000, 32'h0, 0, gv, gw, gs);
      check("refr hold v", gv, C_C);
      check("refr hold spike", gs, 0);
    end
    step_and_check("refr refire", 32'h03E80000, 32'h0, 0, gv, gw, gs);
    check("refr refire spike", gs, 1);
`endif

    // randomized steps against the model
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) apply_reset();
      step_and_check("rand", rand_fx(), rand_fx(), $urandom_range(0, 2), gv, gw, gs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
